iccm_boot_loader: RTL and testbench
===================================

Name: iccm_boot_loader

Overview:
Boot-time sequencer for the instruction memory. It receives a program image as a byte stream from the UART receiver and packs the bytes into 32-bit words. It writes those words into the ICCM through the controller write port and holds the system reset asserted while loading. After the last word is written it releases the system reset so the core boots from ICCM. It also owns the ICCM port-select that hands the memory from the loader to the core's TL-UL adapter.

Parameters:
AW, 12, ICCM word-address width; capacity = 2**AW words
RST_HOLD, 16, cycles the system reset stays asserted after the last write, before release (>=1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset (power-on reset, not the system reset)
rx_dv_i  in  1  one-cycle strobe: rx_byte_i is valid
rx_byte_i  in  8  received UART byte
reprog_i  in  1  level/pulse: abort and restart loading (sampled in RUN only)
iccm_we_o  out  1  one-cycle ICCM write strobe
iccm_addr_o  out  AW  ICCM word address
iccm_wdata_o  out  32  ICCM write data
iccm_sel_o  out  1  1 = loader owns ICCM port, 0 = TL-UL adapter owns it
sys_rst_no  out  1  system reset to core/xbars/peripherals, active low
done_o  out  1  image loaded and core released
err_o  out  1  sticky error (length overflow, or checksum mismatch when enabled)

Behaviour:
- Reset values: iccm_we_o=0, iccm_addr_o=0, iccm_wdata_o=0, iccm_sel_o=1, sys_rst_no=0, done_o=0, err_o=0, state=LEN_LO.
- Bytes are consumed only on cycles with rx_dv_i=1. Back-to-back strobes on consecutive cycles must be accepted.
- States:
  - LEN_LO: latch len[7:0] -> LEN_HI.
  - LEN_HI: latch len[15:8].
    - If len==0 -> HOLD (or CSUM when enabled).
    - If len>2**AW: set err_o, clamp len to 2**AW -> DATA.
    - Otherwise -> DATA.
  - DATA: 2-bit byte counter assembles words little-endian (first byte -> bits[7:0]).
    - On the 4th byte, the next cycle has iccm_we_o=1 for exactly one cycle, with iccm_addr_o=word index and iccm_wdata_o=the assembled word.
    - A byte arriving in that same cycle is accepted into the next word.
    - Word index starts at 0 and increments after each write.
    - After the write of word len-1 -> HOLD (or CSUM).
    - The word index never wraps, because of the clamp.
    - Bytes beyond the clamped length are dropped until the expected count is reached. The stream length still follows the original len; dropped words are counted but not written.
  - HOLD: counter runs RST_HOLD cycles with sys_rst_no=0. At expiry, iccm_sel_o drops to 0 in that same cycle -> RUN.
  - RUN: the cycle after entry, sys_rst_no=1 and done_o=1.
    - rx bytes are ignored.
    - reprog_i=1 -> LEN_LO: sys_rst_no=0, iccm_sel_o=1, done_o=0, err_o cleared. Both reset and port-select take effect in the cycle after reprog_i is sampled.
- iccm_sel_o always changes while sys_rst_no=0, so the core never sees a port switch while running.
- Asynchronous rst_ni mid-load aborts immediately to reset values. A partial word is discarded; ICCM contents already written are kept.
- reprog_i is ignored outside RUN.
- err_o set by length overflow does not block boot.

Optional Feature:
ICCM_LOAD_CSUM_EN:
- Defined: after the last data byte (or after LEN_HI when len==0) the state goes to CSUM.
  - The next byte is compared against the 8-bit modulo-256 sum of all data bytes received, including dropped overflow bytes.
  - Match -> HOLD.
  - Mismatch -> ERROR: err_o=1, sys_rst_no stays 0, iccm_sel_o stays 1. Only rst_ni or reprog_i leaves ERROR (reprog_i is sampled in ERROR too).
- Undefined: no CSUM or ERROR states; the last write goes directly to HOLD.

Test Plan:
1. Stream 08 00 then 11 22 33 44 55 66 77 88 -> writes addr0=0x44332211 and addr1=0x88776655, one we pulse each. sys_rst_no rises exactly RST_HOLD+1 cycles after the second we; done_o=1.
2. Stream 00 00 -> no writes; HOLD of RST_HOLD cycles, then sys_rst_no=1, iccm_sel_o=0.
3. Back-to-back rx_dv_i every cycle for a 3-word image -> all 12 bytes accepted, including the byte coincident with each we cycle; the data words are correct.
4. With AW=2, len=5 words (20 bytes) -> err_o=1; writes only to addresses 0..3; boot still completes after the 20th byte.
5. Assert rst_ni low after 6 data bytes -> all outputs return to reset values within 0 clocks. A fresh 04 00 AA BB CC DD writes 0xDDCCBBAA at addr 0.
6. From RUN, pulse reprog_i and then load 04 00 01 02 03 04 -> sys_rst_no=0 next cycle; write 0x04030201 at addr 0; then re-release. With ICCM_LOAD_CSUM_EN, checksum 0x0A boots; checksum 0x0B -> err_o=1 and reset is held.

Source files
------------

// File: rtl/iccm_boot_loader.sv
// -----------------------------------------------------------------------------
// iccm_boot_loader
//
// Boot-time sequencer for the instruction memory (ICCM). A program image
// arrives as a UART byte stream: a 16-bit little-endian byte length followed
// by the data bytes. Bytes are packed little-endian into 32-bit words and
// written through the ICCM controller write port while the system reset is
// held asserted. After the last word, the system reset is held for RST_HOLD
// more cycles, then the ICCM port is handed to the TL-UL adapter and the
// core is released.
//
// Optional feature (compile-time macro ICCM_LOAD_CSUM_EN): one trailing
// byte carries the modulo-256 sum of all data bytes. On a mismatch the
// loader parks in an error state with the core held in reset.
//
// Parameters
//   AW        ICCM word-address width (capacity 2**AW words)
//   RST_HOLD  cycles of system reset after the last write (>= 1)
//
// Ports
//   clk_i         system clock
//   rst_ni        async active-low power-on reset
//   rx_dv_i       rx_byte_i valid strobe
//   rx_byte_i     received UART byte
//   reprog_i      restart loading (honoured in RUN, and in ERROR if enabled)
//   iccm_we_o     one-cycle ICCM write strobe
//   iccm_addr_o   ICCM word address
//   iccm_wdata_o  ICCM write data
//   iccm_sel_o    1 = loader owns ICCM port, 0 = TL-UL adapter owns it
//   sys_rst_no    active-low system reset to the core and fabric
//   done_o        image loaded and core released
//   err_o         sticky error: length overflow or checksum mismatch
//
// State | meaning
//   LEN_LO | waiting for length byte [7:0]
//   LEN_HI | waiting for length byte [15:8]
//   DATA   | packing data bytes into words and writing them
//   CSUM   | waiting for checksum byte (ICCM_LOAD_CSUM_EN only)
//   HOLD   | system reset held for RST_HOLD cycles
//   RUN    | core released; waits for reprog_i
//   ERROR  | checksum mismatch, core held (ICCM_LOAD_CSUM_EN only)
// -----------------------------------------------------------------------------
module iccm_boot_loader #(
    parameter int unsigned AW       = 12,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          rx_dv_i,
    input  logic [7:0]    rx_byte_i,
    input  logic          reprog_i,
    output logic          iccm_we_o,
    output logic [AW-1:0] iccm_addr_o,
    output logic [31:0]   iccm_wdata_o,
    output logic          iccm_sel_o,
    output logic          sys_rst_no,
    output logic          done_o,
    output logic          err_o
);

    localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);
    // Image capacity in bytes; wide enough that the shift never truncates.
    localparam logic [32:0] CAP_BYTES = 33'(4) << AW;

`ifdef ICCM_LOAD_CSUM_EN
    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA, S_HOLD, S_RUN, S_CSUM, S_ERROR
    } state_e;
`else
    typedef enum logic [2:0] {
        S_LEN_LO, S_LEN_HI, S_DATA, S_HOLD, S_RUN
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [15:0]     rem_q, rem_d;          // data bytes still expected
    logic [AW:0]     idx_q, idx_d;          // word index; MSB set = ICCM full
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     word_q, word_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            sel_q, sel_d;
    logic            srst_q, srst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
`ifdef ICCM_LOAD_CSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic [15:0]     len_w;
    logic [31:0]     word_nxt;

    assign len_w = {rx_byte_i, len_lo_q};

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        hold_d   = hold_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        srst_d   = srst_q;
        done_d   = done_q;
        err_d    = err_q;
`ifdef ICCM_LOAD_CSUM_EN
        csum_d   = csum_q;
`endif
        word_nxt = word_q;
        word_nxt[{bcnt_q, 3'b000} +: 8] = rx_byte_i;

        unique case (state_q)
            S_LEN_LO: begin
                if (rx_dv_i) begin
                    len_lo_d = rx_byte_i;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (rx_dv_i) begin
                    rem_d  = len_w;
                    idx_d  = '0;
                    bcnt_d = '0;
                    word_d = '0;
`ifdef ICCM_LOAD_CSUM_EN
                    csum_d = '0;
`endif
                    if (len_w == 16'd0) begin
`ifdef ICCM_LOAD_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
`endif
                    end else begin
                        // Oversized image: still consume the whole stream,
                        // but writes stop once the ICCM is full.
                        if ({17'd0, len_w} > CAP_BYTES) err_d = 1'b1;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_dv_i) begin
                    rem_d = rem_q - 16'd1;
`ifdef ICCM_LOAD_CSUM_EN
                    csum_d = csum_q + rx_byte_i;
`endif
                    // A trailing partial word is flushed with the last byte.
                    if (bcnt_q == 2'd3 || rem_q == 16'd1) begin
                        bcnt_d = '0;
                        word_d = '0;
                        if (!idx_q[AW]) begin
                            we_d    = 1'b1;
                            addr_d  = idx_q[AW-1:0];
                            wdata_d = word_nxt;
                            idx_d   = idx_q + (AW+1)'(1);
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                        word_d = word_nxt;
                    end
                    if (rem_q == 16'd1) begin
`ifdef ICCM_LOAD_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
`endif
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    // Port handover happens while the core is still in reset.
                    sel_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            S_RUN: begin
                if (reprog_i) begin
                    state_d = S_LEN_LO;
                    srst_d  = 1'b0;
                    sel_d   = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    srst_d = 1'b1;
                    done_d = 1'b1;
                end
            end
`ifdef ICCM_LOAD_CSUM_EN
            S_CSUM: begin
                if (rx_dv_i) begin
                    if (rx_byte_i == csum_q) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ERROR: begin
                if (reprog_i) begin
                    state_d = S_LEN_LO;
                    srst_d  = 1'b0;
                    sel_d   = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
`endif
            default: state_d = S_LEN_LO;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_LEN_LO;
            len_lo_q <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            hold_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= 1'b1;
            srst_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ICCM_LOAD_CSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            hold_q   <= hold_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            srst_q   <= srst_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef ICCM_LOAD_CSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign iccm_we_o    = we_q;
    assign iccm_addr_o  = addr_q;
    assign iccm_wdata_o = wdata_q;
    assign iccm_sel_o   = sel_q;
    assign sys_rst_no   = srst_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_iccm_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_iccm_boot_loader
//
// Directed bench for iccm_boot_loader with a small ICCM (AW=2, 4 words) and
// RST_HOLD=4. ICCM writes and the system-reset release are logged by a
// negedge monitor; expected words are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_iccm_boot_loader;

   localparam int unsigned AW       = 2;
   localparam int unsigned RST_HOLD = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          rx_dv_i = 1'b0;
   logic [7:0]    rx_byte_i = 8'h00;
   logic          reprog_i = 1'b0;
   logic          iccm_we_o;
   logic [AW-1:0] iccm_addr_o;
   logic [31:0]   iccm_wdata_o;
   logic          iccm_sel_o;
   logic          sys_rst_no;
   logic          done_o;
   logic          err_o;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   iccm_boot_loader #(.AW(AW), .RST_HOLD(RST_HOLD)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rx_dv_i      (rx_dv_i),
      .rx_byte_i    (rx_byte_i),
      .reprog_i     (reprog_i),
      .iccm_we_o    (iccm_we_o),
      .iccm_addr_o  (iccm_addr_o),
      .iccm_wdata_o (iccm_wdata_o),
      .iccm_sel_o   (iccm_sel_o),
      .sys_rst_no   (sys_rst_no),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   int            cyc = 0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int            wr_cyc[$];
   int            rise_cyc = -1;
   logic          prev_srst = 1'b0;
   logic          prev_sel  = 1'b1;

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      if (iccm_we_o) begin
         wr_addr.push_back(iccm_addr_o);
         wr_data.push_back(iccm_wdata_o);
         wr_cyc.push_back(cyc);
      end
      if (sys_rst_no && !prev_srst) rise_cyc = cyc;
      if (iccm_sel_o !== prev_sel) chk("sel_change_in_reset", sys_rst_no, 1'b0);
      prev_srst = sys_rst_no;
      prev_sel  = iccm_sel_o;
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      rise_cyc = -1;
   endtask

   task automatic put(input logic [7:0] b);
      @(posedge clk_i); #1;
      rx_dv_i   = 1'b1;
      rx_byte_i = b;
   endtask

   task automatic idle();
      @(posedge clk_i); #1;
      rx_dv_i = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit burst);
      put(b);
      if (!burst) idle();
   endtask

   // Sends length, data and (when enabled) the checksum byte; bad_csum
   // perturbs the checksum.
   task automatic load(input logic [15:0] len, input logic [7:0] d[$],
                       input bit burst, input bit bad_csum);
      logic [7:0] sum;
      sum = 8'h00;
      send(len[7:0], burst);
      send(len[15:8], burst);
      foreach (d[i]) begin
         send(d[i], burst);
         sum = sum + d[i];
      end
`ifdef ICCM_LOAD_CSUM_EN
      send(sum + {7'd0, bad_csum}, burst);
`else
      if (bad_csum) sum = sum + 8'd1;
`endif
      idle();
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 60 && !done_o; i++) @(negedge clk_i);
      @(negedge clk_i);
      chk(tag, done_o, 1'b1);
   endtask

   task automatic reprog_pulse();
      @(posedge clk_i); #1;
      reprog_i = 1'b1;
      @(posedge clk_i); #1;
      reprog_i = 1'b0;
      @(negedge clk_i);
      chk("reprog_sysrst", sys_rst_no, 1'b0);
      chk("reprog_sel", iccm_sel_o, 1'b1);
      chk("reprog_done", done_o, 1'b0);
      chk("reprog_err", err_o, 1'b0);
   endtask

   initial begin
      logic [7:0] d[$];

      // Reset values
      #12;
      chk("rst_we", iccm_we_o, 1'b0);
      chk("rst_addr", iccm_addr_o, 2'd0);
      chk("rst_wdata", iccm_wdata_o, 32'h0);
      chk("rst_sel", iccm_sel_o, 1'b1);
      chk("rst_sysrst", sys_rst_no, 1'b0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_err", err_o, 1'b0);
      rst_ni = 1'b1;

      // 1: two-word image, gapped strobes
      clear_log();
      d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      load(16'd8, d, 1'b0, 1'b0);
      wait_done("t1_done");
      chk("t1_nwr", wr_addr.size(), 2);
      if (wr_addr.size() == 2) begin
         chk("t1_a0", wr_addr[0], 2'd0);
         chk("t1_d0", wr_data[0], 32'h44332211);
         chk("t1_a1", wr_addr[1], 2'd1);
         chk("t1_d1", wr_data[1], 32'h88776655);
`ifndef ICCM_LOAD_CSUM_EN
         chk("t1_release_delay", rise_cyc - wr_cyc[1], RST_HOLD + 1);
`endif
      end
      chk("t1_sysrst", sys_rst_no, 1'b1);
      chk("t1_sel", iccm_sel_o, 1'b0);
      chk("t1_err", err_o, 1'b0);

      // 2: empty image
      reprog_pulse();
      clear_log();
      d.delete();
      load(16'd0, d, 1'b0, 1'b0);
      @(negedge clk_i);
      chk("t2_sysrst_held", sys_rst_no, 1'b0);
      wait_done("t2_done");
      chk("t2_nwr", wr_addr.size(), 0);
      chk("t2_sysrst", sys_rst_no, 1'b1);
      chk("t2_sel", iccm_sel_o, 1'b0);

      // 3: three words, rx_dv every cycle
      reprog_pulse();
      clear_log();
      d.delete();
      for (int i = 0; i < 12; i++) d.push_back(8'h10 + 8'(i));
      load(16'd12, d, 1'b1, 1'b0);
      wait_done("t3_done");
      chk("t3_nwr", wr_addr.size(), 3);
      if (wr_addr.size() == 3) begin
         chk("t3_d0", wr_data[0], 32'h13121110);
         chk("t3_d1", wr_data[1], 32'h17161514);
         chk("t3_a2", wr_addr[2], 2'd2);
         chk("t3_d2", wr_data[2], 32'h1B1A1918);
      end

      // 4: 5-word image into a 4-word ICCM
      reprog_pulse();
      clear_log();
      d.delete();
      for (int i = 0; i < 20; i++) d.push_back(8'hA0 + 8'(i));
      load(16'd20, d, 1'b0, 1'b0);
      chk("t4_err_early", err_o, 1'b1);
      wait_done("t4_done");
      chk("t4_nwr", wr_addr.size(), 4);
      if (wr_addr.size() == 4) begin
         chk("t4_a3", wr_addr[3], 2'd3);
         chk("t4_d3", wr_data[3], 32'hAFAEADAC);
      end
      chk("t4_err", err_o, 1'b1);
      chk("t4_sysrst", sys_rst_no, 1'b1);

      // 6a: reprog clears err, then reload
      reprog_pulse();
      clear_log();
      d = '{8'h01, 8'h02, 8'h03, 8'h04};
      load(16'd4, d, 1'b0, 1'b0);
      wait_done("t6_done");
      chk("t6_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) begin
         chk("t6_a0", wr_addr[0], 2'd0);
         chk("t6_d0", wr_data[0], 32'h04030201);
      end
      chk("t6_sysrst", sys_rst_no, 1'b1);

`ifdef ICCM_LOAD_CSUM_EN
      // 6b: bad checksum holds the core in reset
      reprog_pulse();
      load(16'd4, d, 1'b0, 1'b1);
      repeat (RST_HOLD + 6) @(negedge clk_i);
      chk("t6_bad_err", err_o, 1'b1);
      chk("t6_bad_sysrst", sys_rst_no, 1'b0);
      chk("t6_bad_sel", iccm_sel_o, 1'b1);
      chk("t6_bad_done", done_o, 1'b0);
      reprog_pulse();
`else
      reprog_pulse();
`endif

      // 5: async reset after 6 data bytes, then a fresh load
      clear_log();
      send(8'h08, 1'b0);
      send(8'h00, 1'b0);
      for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i), 1'b0);
      @(negedge clk_i);
      chk("t5_partial_nwr", wr_addr.size(), 1);
      rst_ni = 1'b0;
      #1;
      chk("t5_we", iccm_we_o, 1'b0);
      chk("t5_addr", iccm_addr_o, 2'd0);
      chk("t5_wdata", iccm_wdata_o, 32'h0);
      chk("t5_sel", iccm_sel_o, 1'b1);
      chk("t5_sysrst", sys_rst_no, 1'b0);
      chk("t5_done", done_o, 1'b0);
      #10;
      rst_ni = 1'b1;
      clear_log();
      d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      load(16'd4, d, 1'b0, 1'b0);
      wait_done("t5_done_after");
      chk("t5_nwr", wr_addr.size(), 1);
      if (wr_addr.size() == 1) begin
         chk("t5_a0", wr_addr[0], 2'd0);
         chk("t5_d0", wr_data[0], 32'hDDCCBBAA);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
